// File: rtl/db9_sega_multi_reader.sv
// rtl/db9_sega_multi_reader.sv - self-timed Mega Drive 3/6-button pad reader for one or two DB9 ports
module db9_sega_multi_reader #(
    parameter int NUM_PORTS    = 1,
    parameter int PHASE_CYCLES = 480,
    parameter int IDLE_CYCLES  = 76800
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5:0]              db9_i,
    output logic                    db9_select,
    output logic                    splitter_select,
    output logic [12*NUM_PORTS-1:0] joy_o,
    output logic [NUM_PORTS-1:0]    six_button_o,
    output logic [NUM_PORTS-1:0]    connected_o,
    output logic                    frame_done
);

    localparam int MAX_CYCLES = (IDLE_CYCLES > PHASE_CYCLES) ? IDLE_CYCLES : PHASE_CYCLES;
    localparam int CW = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] PHASE_LAST = CW'(PHASE_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LAST  = CW'(IDLE_CYCLES - 1);

    typedef enum logic [3:0] {
        P0, P1, P2, P3, P4, P5, P6, P7, IDLE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [5:0]    sync_q1;
    logic [5:0]    sync_q2;
    logic [5:0]    smp_p0;
    logic [1:0]    smp_as;
    logic [3:0]    smp_p6;
    logic          det_sega;
    logic          det_six;
    logic [11:0]   new_word;

    // Pins are active-low; the word layout is M X Y Z S A C B R L D U
    always_comb begin
        new_word     = 12'h000;
        new_word[0]  = ~smp_p0[3];
        new_word[1]  = ~smp_p0[2];
        new_word[2]  = ~smp_p0[1];
        new_word[3]  = ~smp_p0[0];
        new_word[4]  = ~smp_p0[4];
        new_word[5]  = ~smp_p0[5];
        new_word[6]  = ~smp_as[0] & det_sega;
        new_word[7]  = ~smp_as[1] & det_sega;
        new_word[8]  = ~smp_p6[3] & det_six;
        new_word[9]  = ~smp_p6[2] & det_six;
        new_word[10] = ~smp_p6[1] & det_six;
        new_word[11] = ~smp_p6[0] & det_six;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1         <= 6'h3F;
            sync_q2         <= 6'h3F;
        end else begin
            sync_q1         <= db9_i;
            sync_q2         <= sync_q1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= P0;
            cnt             <= '0;
            db9_select      <= 1'b1;
            splitter_select <= 1'b0;
            joy_o           <= '0;
            six_button_o    <= '0;
            connected_o     <= '0;
            frame_done      <= 1'b0;
            smp_p0          <= 6'h3F;
            smp_as          <= 2'b11;
            smp_p6          <= 4'hF;
            det_sega        <= 1'b0;
            det_six         <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == IDLE) begin
                if (cnt == IDLE_LAST) begin
                    cnt        <= '0;
                    state      <= P0;
                    db9_select <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (cnt == PHASE_LAST) begin
                cnt <= '0;
                case (state)
                    P0: smp_p0 <= sync_q2;
                    P1: begin
                        smp_as   <= sync_q2[5:4];
                        det_sega <= ~sync_q2[1] & ~sync_q2[0];
                    end
                    P5: det_six <= ~|sync_q2[3:0];
                    P6: smp_p6  <= sync_q2[3:0];
                    default: ;
                endcase
                if (state == P7) begin
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (p == int'(splitter_select)) begin
                            joy_o[12*p +: 12] <= new_word;
                            connected_o[p]    <= det_sega;
                            six_button_o[p]   <= det_sega & det_six;
                        end
                    end
                    frame_done <= 1'b1;
                    state      <= IDLE;
                    db9_select <= 1'b1;
                    // Switch the mux now so it has the whole idle gap to settle
                    if (NUM_PORTS == 2)
                        splitter_select <= ~splitter_select;
                end else begin
                    state      <= state_t'(state + 4'd1);
                    // Next phase is odd (select low) exactly when this one is even
                    db9_select <= state[0];
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_db9_sega_multi_reader.sv
// tb/tb_db9_sega_multi_reader.sv - scoreboard bench for db9_sega_multi_reader with pad models
module tb_db9_sega_multi_reader;

    logic        clk;
    logic        reset;
    logic [5:0]  db9_1, db9_2;
    logic        sel1, sel2, spl1, spl2, fd1, fd2;
    logic [11:0] joy1;
    logic [23:0] joy2;
    logic [0:0]  six1, conn1;
    logic [1:0]  six2, conn2;

    db9_sega_multi_reader #(.NUM_PORTS(1), .PHASE_CYCLES(4), .IDLE_CYCLES(16)) dut1 (
        .clk(clk), .reset(reset), .db9_i(db9_1), .db9_select(sel1),
        .splitter_select(spl1), .joy_o(joy1), .six_button_o(six1),
        .connected_o(conn1), .frame_done(fd1)
    );

    db9_sega_multi_reader #(.NUM_PORTS(2), .PHASE_CYCLES(4), .IDLE_CYCLES(16)) dut2 (
        .clk(clk), .reset(reset), .db9_i(db9_2), .db9_select(sel2),
        .splitter_select(spl2), .joy_o(joy2), .six_button_o(six2),
        .connected_o(conn2), .frame_done(fd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pad 0 feeds dut1; pads 1 and 2 sit behind dut2's splitter (port 0, port 1)
    int          ptype [3];
    logic [11:0] pmask [3];
    int          lowcnt[3];
    int          hicnt [3];
    logic        prev_sel[3];
    logic [5:0]  ppins [3];

    function automatic logic [5:0] pad_pins(int t, logic [11:0] m, logic sel, int lc);
        logic [11:0] n;
        n = ~m;
        if (t == 0) return 6'h3F;
        if (sel) begin
            if (t == 6 && lc == 3) return {n[5], n[4], n[8], n[9], n[10], n[11]};
            return {n[5], n[4], n[0], n[1], n[2], n[3]};
        end
        if (t == 6 && lc == 3) return {n[7], n[6], 4'b0000};
        if (t == 6 && lc == 4) return {n[7], n[6], 4'b1111};
        return {n[7], n[6], n[0], n[1], 2'b00};
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic s;
            s = (i == 0) ? sel1 : sel2;
            if (prev_sel[i] && !s) lowcnt[i]++;
            if (s) begin
                hicnt[i]++;
                if (hicnt[i] >= 8) lowcnt[i] = 0;
            end else begin
                hicnt[i] = 0;
            end
            prev_sel[i] = s;
            ppins[i] = pad_pins(ptype[i], pmask[i], s, lowcnt[i]);
        end
    end

    assign db9_1 = ppins[0];
    assign db9_2 = spl2 ? ppins[2] : ppins[1];

    typedef struct { logic [11:0] joy; logic six; logic conn; } exp1_t;
    typedef struct { logic [23:0] joy; logic [1:0] six; logic [1:0] conn; } exp2_t;
    exp1_t q1[$];
    exp2_t q2[$];
    exp2_t cur2;
    int    np;

    function automatic logic [11:0] expect_word(int t, logic [11:0] m);
        if (t == 0) return 12'h000;
        if (t == 3) return {4'h0, m[7:0]};
        return m;
    endfunction

    task automatic rand_pad(input int i);
        logic [11:0] m;
        int          r;
        r = $urandom_range(0, 2);
        m = 12'($urandom);
        ptype[i] = (r == 0) ? 0 : ((r == 1) ? 3 : 6);
        if (ptype[i] == 3) begin
            m[11:8] = 4'h0;
            if (m[0] && m[1]) m[1] = 1'b0;
        end
        pmask[i] = m;
    endtask

    task automatic push_frame();
        exp1_t e1;
        exp2_t e2;
        e1.joy  = expect_word(ptype[0], pmask[0]);
        e1.six  = (ptype[0] == 6);
        e1.conn = (ptype[0] != 0);
        q1.push_back(e1);
        e2 = cur2;
        e2.joy[12*np +: 12] = expect_word(ptype[1+np], pmask[1+np]);
        e2.six[np]  = (ptype[1+np] == 6);
        e2.conn[np] = (ptype[1+np] != 0);
        q2.push_back(e2);
        cur2 = e2;
        np   = 1 - np;
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fd1 && n < 100);
        check("frame_done_seen", {31'd0, fd1}, 32'd1);
    endtask

    task automatic measure_latency(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fd1 && n < 100);
        n_checks++;
        if (n < 32 || n > 34) begin
            n_fail++;
            $display("FAIL %s: got %0d cycles expected 32..34", name, n);
        end
    endtask

    task automatic check_reset_values();
        check("rst_sel1", {31'd0, sel1}, 32'd1);
        check("rst_spl1", {31'd0, spl1}, 32'd0);
        check("rst_joy1", {20'd0, joy1}, 32'd0);
        check("rst_six_conn1", {30'd0, six1, conn1}, 32'd0);
        check("rst_fd1", {31'd0, fd1}, 32'd0);
        check("rst_sel2", {31'd0, sel2}, 32'd1);
        check("rst_spl2", {31'd0, spl2}, 32'd0);
        check("rst_joy2", {8'd0, joy2}, 32'd0);
        check("rst_six_conn2", {28'd0, six2, conn2}, 32'd0);
        check("rst_fd2", {31'd0, fd2}, 32'd0);
    endtask

    // dut1 monitor: scoreboard, frame period, select pulse shape
    int cyc = 0, last_fd = -1, run = 0, lowp = 0, since_fd = 1000;
    logic prev_fd = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            last_fd = -1; run = 0; lowp = 0; since_fd = 1000; prev_fd = 1'b0;
        end else begin
            if (!sel1) begin
                run++;
            end else begin
                if (run > 0) begin
                    check("select_low_width", run, 32'd4);
                    lowp++;
                end
                run = 0;
            end
            if (fd1) begin
                if (q1.size() == 0) begin
                    check("dut1_frame_expected", 32'd0, 32'd1);
                end else begin
                    exp1_t e;
                    e = q1.pop_front();
                    check("dut1_joy", {20'd0, joy1}, {20'd0, e.joy});
                    check("dut1_six", {31'd0, six1}, {31'd0, e.six});
                    check("dut1_conn", {31'd0, conn1}, {31'd0, e.conn});
                end
                check("dut1_splitter_zero", {31'd0, spl1}, 32'd0);
                check("fd1_width", {31'd0, prev_fd}, 32'd0);
                if (last_fd >= 0) check("fd1_period", cyc - last_fd, 32'd48);
                check("select_pulses_per_frame", lowp, 32'd4);
                last_fd = cyc; lowp = 0; since_fd = 0;
            end else begin
                since_fd++;
            end
            if (since_fd < 16) check("select_high_in_idle", {31'd0, sel1}, 32'd1);
            prev_fd = fd1;
        end
    end

    // dut2 monitor: scoreboard and splitter behaviour
    logic prev_spl = 1'b0, exp_spl = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_spl = spl2; exp_spl = 1'b0;
        end else begin
            if (spl2 != prev_spl) check("splitter_toggle_on_idle_entry", {31'd0, fd2}, 32'd1);
            if (fd2) begin
                if (q2.size() == 0) begin
                    check("dut2_frame_expected", 32'd0, 32'd1);
                end else begin
                    exp2_t e;
                    e = q2.pop_front();
                    check("dut2_joy", {8'd0, joy2}, {8'd0, e.joy});
                    check("dut2_six", {30'd0, six2}, {30'd0, e.six});
                    check("dut2_conn", {30'd0, conn2}, {30'd0, e.conn});
                end
                exp_spl = ~exp_spl;
                check("dut2_splitter", {31'd0, spl2}, {31'd0, exp_spl});
            end
            prev_spl = spl2;
        end
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ptype[i] = 0; pmask[i] = 12'h000; lowcnt[i] = 0; hicnt[i] = 0;
            prev_sel[i] = 1'b1; ppins[i] = 6'h3F;
        end
        cur2 = '{joy: 24'h0, six: 2'b00, conn: 2'b00};
        np   = 0;
        ptype[0] = 3; pmask[0] = 12'h021;
        ptype[1] = 3; pmask[1] = 12'h010;
        ptype[2] = 3; pmask[2] = 12'h008;
        repeat (4) @(negedge clk);
        check_reset_values();
        push_frame();
        reset = 1'b0;
        measure_latency("first_frame_latency");

        ptype[0] = 6; pmask[0] = 12'h480;
        push_frame();
        wait_fd();
        ptype[0] = 6; pmask[0] = 12'h080;
        rand_pad(1); rand_pad(2);
        push_frame();
        wait_fd();
        ptype[0] = 0;
        rand_pad(1); rand_pad(2);
        push_frame();
        wait_fd();
        repeat (8) @(negedge clk);
        ptype[0] = 6; pmask[0] = 12'($urandom);
        rand_pad(1); rand_pad(2);
        push_frame();
        for (int f = 0; f < 20; f++) begin
            wait_fd();
            repeat ($urandom_range(0, 8)) @(negedge clk);
            rand_pad(0); rand_pad(1); rand_pad(2);
            push_frame();
        end
        wait_fd();

        // Abandon a frame in the middle of P3
        repeat (30) @(negedge clk);
        check("mid_p3_select_low", {31'd0, sel1}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        q1.delete();
        q2.delete();
        cur2 = '{joy: 24'h0, six: 2'b00, conn: 2'b00};
        np   = 0;
        rand_pad(0); rand_pad(1); rand_pad(2);
        push_frame();
        repeat (10) @(negedge clk);
        reset = 1'b0;
        measure_latency("post_reset_latency");
        for (int f = 0; f < 4; f++) begin
            rand_pad(0); rand_pad(1); rand_pad(2);
            push_frame();
            wait_fd();
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
